// File: rtl/seg8_4_display.sv
// Four-digit multiplexed 7-segment hex display driver.
// One digit is scanned per step. Digit selects and segments are active-low.
// Every output comes directly from a flop, so nothing downstream sees a glitch.
module seg8_4_display #(
  parameter int SCAN_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] number,
  input  logic [3:0]  dot,
  output logic [3:0]  sel,
  output logic [7:0]  seg
);

  // One extra prescaler bit keeps the counter at least 1 bit wide when SCAN_DIV=1.
  localparam int             CW      = $clog2(SCAN_DIV) + 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);

  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    sel_q, sel_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    nib_s;
  logic          dp_s;

  // Hex font, active-high, bit order gfedcba.
  function automatic logic [6:0] hex_font(input logic [3:0] v);
    logic [6:0] f;
    case (v)
      4'h0:    f = 7'h3F;
      4'h1:    f = 7'h06;
      4'h2:    f = 7'h5B;
      4'h3:    f = 7'h4F;
      4'h4:    f = 7'h66;
      4'h5:    f = 7'h6D;
      4'h6:    f = 7'h7D;
      4'h7:    f = 7'h07;
      4'h8:    f = 7'h7F;
      4'h9:    f = 7'h6F;
      4'hA:    f = 7'h77;
      4'hB:    f = 7'h7C;
      4'hC:    f = 7'h39;
      4'hD:    f = 7'h5E;
      4'hE:    f = 7'h79;
      4'hF:    f = 7'h71;
      default: f = 7'h00;
    endcase
    return f;
  endfunction

  // Choose the nibble, the dot and the one-hot-low select for the digit now being scanned.
  always_comb begin
    nib_s = 4'h0;
    sel_d = 4'b1111;
    case (idx_q)
      2'd0: begin nib_s = number[3:0];   sel_d = 4'b1110; end
      2'd1: begin nib_s = number[7:4];   sel_d = 4'b1101; end
      2'd2: begin nib_s = number[11:8];  sel_d = 4'b1011; end
      2'd3: begin nib_s = number[15:12]; sel_d = 4'b0111; end
      default: begin nib_s = 4'h0;       sel_d = 4'b1111; end
    endcase
    dp_s  = dot[idx_q];
    seg_d = ~{dp_s, hex_font(nib_s)};
  end

  // Prescaler: hold each digit for SCAN_DIV edges, then advance the index. The index wraps from 3 back to 0.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
      idx_d = idx_q;
    end
  end

  // Scan state and output registers. Reset blanks the display and restarts at digit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= 2'd0;
      cnt_q <= '0;
      sel_q <= 4'b1111;
      seg_q <= 8'hFF;
    end else begin
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      seg_q <= seg_d;
    end
  end

  assign sel = sel_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_seg8_4_display.sv
// Directed, table-driven bench for seg8_4_display (SCAN_DIV=1 and SCAN_DIV=4).
module tb_seg8_4_display;

  logic        clk = 1'b0;
  logic        rst1, rst4;
  logic [15:0] number1, number4;
  logic [3:0]  dot1, dot4;
  logic [3:0]  sel1, sel4;
  logic [7:0]  seg1, seg4;

  int check_cnt = 0;
  int pass_cnt  = 0;

  always #5 clk = ~clk;

  seg8_4_display #(.SCAN_DIV(1)) dut1 (
    .clk(clk), .rst(rst1), .number(number1), .dot(dot1), .sel(sel1), .seg(seg1)
  );

  seg8_4_display #(.SCAN_DIV(4)) dut4 (
    .clk(clk), .rst(rst4), .number(number4), .dot(dot4), .sel(sel4), .seg(seg4)
  );

  typedef struct {
    logic        rst;
    logic [15:0] number;
    logic [3:0]  dot;
    logic [3:0]  exp_sel;
    logic [7:0]  exp_seg;
  } vec_t;

  vec_t vecs[$];

  // Inverted segment codes (dp off), hand-derived from the font table.
  logic [7:0] seg_inv [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [3:0] sel_seq [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %02h expected %02h", name, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic [15:0] n, input logic [3:0] d,
                              input logic [3:0] s, input logic [7:0] g);
    vec_t v;
    v.rst = r; v.number = n; v.dot = d; v.exp_sel = s; v.exp_seg = g;
    return v;
  endfunction

  initial begin
    bit found;
    rst1 = 1'b1; number1 = 16'h1234; dot1 = 4'h0;
    rst4 = 1'b1; number4 = 16'h00F0; dot4 = 4'h0;

    // Reset, then digit 0 = nibble 4, digit 1 = 3, digit 2 = 2, digit 3 = 1.
    vecs.push_back(mk(1'b1, 16'h1234, 4'h0, 4'hF, 8'hFF));
    vecs.push_back(mk(1'b1, 16'h1234, 4'h0, 4'hF, 8'hFF));
    for (int r = 0; r < 2; r++) begin
      vecs.push_back(mk(1'b0, 16'h1234, 4'h0, 4'hE, 8'h99));
      vecs.push_back(mk(1'b0, 16'h1234, 4'h0, 4'hD, 8'hB0));
      vecs.push_back(mk(1'b0, 16'h1234, 4'h0, 4'hB, 8'hA4));
      vecs.push_back(mk(1'b0, 16'h1234, 4'h0, 4'h7, 8'hF9));
    end
    // Font sweep 0000..FFFF in steps of 1111, one full frame per value.
    for (int v = 0; v < 16; v++)
      for (int k = 0; k < 4; k++)
        vecs.push_back(mk(1'b0, 16'(v * 16'h1111), 4'h0, sel_seq[k], seg_inv[v]));
    // Dots on digits 0 and 2.
    vecs.push_back(mk(1'b0, 16'h0000, 4'b0101, 4'hE, 8'h40));
    vecs.push_back(mk(1'b0, 16'h0000, 4'b0101, 4'hD, 8'hC0));
    vecs.push_back(mk(1'b0, 16'h0000, 4'b0101, 4'hB, 8'h40));
    vecs.push_back(mk(1'b0, 16'h0000, 4'b0101, 4'h7, 8'hC0));

    #2;
    foreach (vecs[i]) begin
      rst1 = vecs[i].rst; number1 = vecs[i].number; dot1 = vecs[i].dot;
      tick();
      check($sformatf("vec%0d_sel", i), {4'h0, sel1}, {4'h0, vecs[i].exp_sel});
      check($sformatf("vec%0d_seg", i), seg1, vecs[i].exp_seg);
    end

    // Mid-scan reset while digit 2 is active.
    number1 = 16'h1234; dot1 = 4'h0;
    found = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      tick();
      if (sel1 == 4'hB) found = 1'b1;
    end
    check("reach_digit2", {7'h00, found}, 8'h01);
    rst1 = 1'b1;
    tick();
    check("midrst_sel", {4'h0, sel1}, 8'h0F);
    check("midrst_seg", seg1, 8'hFF);
    tick();
    check("midrst_hold_sel", {4'h0, sel1}, 8'h0F);
    rst1 = 1'b0;
    tick();
    check("restart_sel", {4'h0, sel1}, 8'h0E);
    check("restart_seg", seg1, 8'h99);

    // Live update: change the value while digit 2 is shown; digit 0 picks it up on its next refresh.
    number1 = 16'h0000;
    found = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      tick();
      if (sel1 == 4'hB) found = 1'b1;
    end
    check("live_reach_digit2", {7'h00, found}, 8'h01);
    check("live_digit2_seg", seg1, 8'hC0);
    number1 = 16'h000F;
    tick();
    check("live_digit3_sel", {4'h0, sel1}, 8'h07);
    check("live_digit3_seg", seg1, 8'hC0);
    tick();
    check("live_digit0_sel", {4'h0, sel1}, 8'h0E);
    check("live_digit0_seg", seg1, 8'h8E);

    // SCAN_DIV=4: each digit is held for 4 edges, and digit 1 shows F.
    tick();
    check("div4_rst_sel", {4'h0, sel4}, 8'h0F);
    check("div4_rst_seg", seg4, 8'hFF);
    rst4 = 1'b0;
    for (int e = 0; e < 20; e++) begin
      tick();
      check($sformatf("div4_e%0d_sel", e), {4'h0, sel4}, {4'h0, sel_seq[(e / 4) % 4]});
      check($sformatf("div4_e%0d_seg", e), seg4, (((e / 4) % 4) == 1) ? 8'h8E : 8'hC0);
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
